sdio_dev_cmd: RTL and testbench

Card-side SDIO command-line responder: the device end of the host command interface in the uDMA SDIO subsystem. It deserialises 48-bit host command frames from the CMD line, checks CRC7 and framing, hands index/argument to device logic, then serialises the response (none, 48-bit with/without CRC7, or 136-bit R2) back on the same line after the N_CR gap. It is used as a synthesizable card model for host-controller verification and as the command front end of a device core.

---
 rtl/sdio_dev_cmd.sv | 212 +++++++++++++++++++++
 tb/tb_sdio_dev_cmd.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdio_dev_cmd.sv
// Card-side SDIO CMD-line responder. It receives 48-bit host commands, checks CRC7 and
// framing, then sends the device's none/R1/R3/R2 reply after the N_CR gap.
//   state    | meaning
//   IDLE     | line released, hunting for a start bit
//   RX       | shifting in command bits 1..47
//   WAIT_RSP | good command seen, waiting for response request and N_CR gap
//   TX       | driving the response frame on CMD
//   RELEASE  | one released cycle before returning to IDLE
module sdio_dev_cmd #(
  parameter int NCR     = 2,
  parameter int NCR_MAX = 64
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         sdcmd_i,
  output logic         sdcmd_o,
  output logic         sdcmd_oen_o,
  output logic         cmd_valid_o,
  output logic         cmd_err_o,
  output logic [5:0]   cmd_index_o,
  output logic [31:0]  cmd_arg_o,
  output logic         rsp_ready_o,
  input  logic         rsp_valid_i,
  input  logic [1:0]   rsp_type_i,
  input  logic [5:0]   rsp_index_i,
  input  logic [31:0]  rsp_arg_i,
  input  logic [119:0] rsp_data_i,
  output logic         rsp_timeout_o,
  output logic         busy_o
);

  typedef enum logic [2:0] {IDLE, RX, WAIT_RSP, TX, RELEASE} state_t;

  localparam logic [6:0] NCR_L     = 7'(NCR);
  localparam logic [6:0] NCR_MAX_L = 7'(NCR_MAX);

  state_t         state;
  logic [7:0]     bit_cnt;
  logic [6:0]     gap_cnt;
  logic [6:0]     gap_next;
  logic [44:0]    rx_sr;
  logic [6:0]     rx_crc;
  logic [135:0]   tx_sr;
  logic [6:0]     tx_crc;
  logic [6:0]     tx_crc_next;
  logic           tx_long;
  logic           tx_use_crc;
  logic           rsp_held;
  logic [7:0]     tx_pos;
  logic [7:0]     tx_len;
  logic           crc_in;
  logic           crc_out;
  logic           tx_bit;
  logic           rx_good;

  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
    logic fb;
    fb = crc[6] ^ din;
    return {crc[5:3], crc[2] ^ fb, crc[1:0], fb};
  endfunction

  assign gap_next = (gap_cnt == 7'h7F) ? gap_cnt : gap_cnt + 7'd1;

  // When bit 47 is on the line, rx_sr holds bits 2..46: the CRC field sits in rx_sr[6:0]
  assign rx_good = (rx_sr[6:0] == rx_crc) && sdcmd_i;

  // The CRC window covers bits 0..39 for 48-bit frames and only the data bits 8..127 for R2
  always_comb begin
    tx_pos = (state == TX) ? bit_cnt : 8'd0;
    tx_len = tx_long ? 8'd136 : 8'd48;
    if (tx_long) begin
      crc_in  = tx_use_crc && (tx_pos >= 8'd8) && (tx_pos < 8'd128);
      crc_out = tx_use_crc && (tx_pos >= 8'd128) && (tx_pos < 8'd135);
    end else begin
      crc_in  = tx_use_crc && (tx_pos < 8'd40);
      crc_out = tx_use_crc && (tx_pos >= 8'd40) && (tx_pos < 8'd47);
    end
    tx_bit = crc_out ? tx_crc[6] : tx_sr[135];
    if (crc_in) begin
      tx_crc_next = crc7_step(tx_crc, tx_sr[135]);
    end else if (crc_out) begin
      tx_crc_next = {tx_crc[5:0], 1'b0};
    end else begin
      tx_crc_next = tx_crc;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= IDLE;
      bit_cnt       <= 8'd0;
      gap_cnt       <= 7'd0;
      rx_sr         <= '0;
      rx_crc        <= 7'd0;
      tx_sr         <= '1;
      tx_crc        <= 7'd0;
      tx_long       <= 1'b0;
      tx_use_crc    <= 1'b0;
      rsp_held      <= 1'b0;
      sdcmd_o       <= 1'b1;
      sdcmd_oen_o   <= 1'b1;
      cmd_valid_o   <= 1'b0;
      cmd_err_o     <= 1'b0;
      cmd_index_o   <= 6'd0;
      cmd_arg_o     <= 32'd0;
      rsp_ready_o   <= 1'b0;
      rsp_timeout_o <= 1'b0;
      busy_o        <= 1'b0;
    end else begin
      cmd_valid_o   <= 1'b0;
      cmd_err_o     <= 1'b0;
      rsp_timeout_o <= 1'b0;
      case (state)
        IDLE: begin
          if (!sdcmd_i) begin
            state   <= RX;
            bit_cnt <= 8'd1;
            rx_sr   <= '0;
            rx_crc  <= 7'd0;
            busy_o  <= 1'b1;
          end
        end

        RX: begin
          if ((bit_cnt == 8'd1) && !sdcmd_i) begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end else if (bit_cnt == 8'd47) begin
            cmd_index_o <= rx_sr[44:39];
            cmd_arg_o   <= rx_sr[38:7];
            gap_cnt     <= 7'd0;
            if (rx_good) begin
              cmd_valid_o <= 1'b1;
              rsp_ready_o <= 1'b1;
              rsp_held    <= 1'b0;
              state       <= WAIT_RSP;
            end else begin
              cmd_err_o <= 1'b1;
              busy_o    <= 1'b0;
              state     <= IDLE;
            end
          end else begin
            rx_sr   <= {rx_sr[43:0], sdcmd_i};
            if (bit_cnt <= 8'd39) begin
              rx_crc <= crc7_step(rx_crc, sdcmd_i);
            end
            bit_cnt <= bit_cnt + 8'd1;
          end
        end

        WAIT_RSP: begin
          gap_cnt <= gap_next;
          if (!rsp_held) begin
            if (rsp_valid_i && rsp_ready_o) begin
              rsp_ready_o <= 1'b0;
              tx_crc      <= 7'd0;
              tx_long     <= (rsp_type_i == 2'd3);
              tx_use_crc  <= (rsp_type_i != 2'd2);
              case (rsp_type_i)
                2'd1:    tx_sr <= {2'b00, rsp_index_i, rsp_arg_i, {96{1'b1}}};
                2'd2:    tx_sr <= {2'b00, 6'h3F, rsp_arg_i, {96{1'b1}}};
                default: tx_sr <= {2'b00, 6'h3F, rsp_data_i, 8'hFF};
              endcase
              if (rsp_type_i == 2'd0) begin
                busy_o <= 1'b0;
                state  <= IDLE;
              end else begin
                rsp_held <= 1'b1;
              end
            end else if (gap_next >= NCR_MAX_L) begin
              rsp_ready_o   <= 1'b0;
              rsp_timeout_o <= 1'b1;
              busy_o        <= 1'b0;
              state         <= IDLE;
            end
          end else if (gap_next >= NCR_L) begin
            sdcmd_o     <= tx_bit;
            sdcmd_oen_o <= 1'b0;
            tx_sr       <= {tx_sr[134:0], 1'b1};
            tx_crc      <= tx_crc_next;
            bit_cnt     <= 8'd1;
            state       <= TX;
          end
        end

        TX: begin
          if (bit_cnt == tx_len) begin
            sdcmd_o     <= 1'b1;
            sdcmd_oen_o <= 1'b1;
            state       <= RELEASE;
          end else begin
            sdcmd_o <= tx_bit;
            tx_sr   <= {tx_sr[134:0], 1'b1};
            tx_crc  <= tx_crc_next;
            bit_cnt <= bit_cnt + 8'd1;
          end
        end

        RELEASE: begin
          busy_o <= 1'b0;
          state  <= IDLE;
        end

        default: begin
          busy_o <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdio_dev_cmd.sv
// Bench for sdio_dev_cmd. A per-transaction timing model predicts every output on every cycle.
// Directed frames with known literals are followed by randomised traffic.
module tb_sdio_dev_cmd;
  localparam int NCR     = 2;
  localparam int NCR_MAX = 64;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic         sdcmd_i = 1'b1;
  logic         rsp_valid_i = 1'b0;
  logic [1:0]   rsp_type_i = 2'd0;
  logic [5:0]   rsp_index_i = 6'd0;
  logic [31:0]  rsp_arg_i = 32'd0;
  logic [119:0] rsp_data_i = '0;
  logic         sdcmd_o, sdcmd_oen_o, cmd_valid_o, cmd_err_o, rsp_ready_o, rsp_timeout_o, busy_o;
  logic [5:0]   cmd_index_o;
  logic [31:0]  cmd_arg_o;

  sdio_dev_cmd #(.NCR(NCR), .NCR_MAX(NCR_MAX)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .sdcmd_i(sdcmd_i), .sdcmd_o(sdcmd_o),
    .sdcmd_oen_o(sdcmd_oen_o), .cmd_valid_o(cmd_valid_o), .cmd_err_o(cmd_err_o),
    .cmd_index_o(cmd_index_o), .cmd_arg_o(cmd_arg_o), .rsp_ready_o(rsp_ready_o),
    .rsp_valid_i(rsp_valid_i), .rsp_type_i(rsp_type_i), .rsp_index_i(rsp_index_i),
    .rsp_arg_i(rsp_arg_i), .rsp_data_i(rsp_data_i), .rsp_timeout_o(rsp_timeout_o),
    .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  // Expected behaviour as cycle windows: the output seen after edge k is checked while cyc == k
  int busy_lo = 1, busy_hi = 0, rdy_lo = 1, rdy_hi = 0;
  int tx_s = -1, tx_len = 0, tx_cut = 1 << 30;
  int valid_c = -1, err_c = -1, to_c = -1, upd_c = 1 << 30;
  logic [5:0]   upd_index = 6'd0, cur_index = 6'd0;
  logic [31:0]  upd_arg = 32'd0, cur_arg = 32'd0;
  logic [135:0] tx_frame = '1;
  logic         tx_on;

  logic [135:0] cap = '0;
  int           cap_n = 0;
  int           first_lo = -1;

  task automatic chk(input string nm, input logic [135:0] act, input logic [135:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [6:0] crc7(input logic [135:0] v, input int n);
    logic [6:0] c;
    logic       fb;
    c = 7'd0;
    for (int i = n - 1; i >= 0; i--) begin
      fb = c[6] ^ v[i];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  function automatic logic [47:0] make_cmd(input logic [5:0] idx, input logic [31:0] arg);
    logic [39:0] head;
    head = {2'b01, idx, arg};
    return {head, crc7({96'd0, head}, 40), 1'b1};
  endfunction

  function automatic logic [135:0] rsp_frame(input logic [1:0] t, input logic [5:0] idx,
                                             input logic [31:0] arg, input logic [119:0] data);
    logic [39:0] head;
    head = {2'b00, idx, arg};
    case (t)
      2'd1:    return {head, crc7({96'd0, head}, 40), 1'b1, 88'd0};
      2'd2:    return {2'b00, 6'h3F, arg, 8'hFF, 88'd0};
      default: return {2'b00, 6'h3F, data, crc7({16'd0, data}, 120), 1'b1};
    endcase
  endfunction

  function automatic logic [119:0] rnd120();
    logic [127:0] t;
    t = {$urandom, $urandom, $urandom, $urandom};
    return t[119:0];
  endfunction

  always @(negedge clk_i) begin
    if (cyc >= 1) begin
      tx_on = (cyc >= tx_s) && (cyc < tx_s + tx_len) && (cyc <= tx_cut);
      if (cyc >= upd_c) begin
        cur_index = upd_index;
        cur_arg   = upd_arg;
      end
      chk("sdcmd_oen", sdcmd_oen_o, !tx_on);
      chk("sdcmd", sdcmd_o, tx_on ? tx_frame[135 - (cyc - tx_s)] : 1'b1);
      chk("cmd_valid", cmd_valid_o, cyc == valid_c);
      chk("cmd_err", cmd_err_o, cyc == err_c);
      chk("rsp_timeout", rsp_timeout_o, cyc == to_c);
      chk("busy", busy_o, (cyc >= busy_lo) && (cyc <= busy_hi));
      chk("rsp_ready", rsp_ready_o, (cyc >= rdy_lo) && (cyc <= rdy_hi));
      chk("cmd_index", cmd_index_o, cur_index);
      chk("cmd_arg", cmd_arg_o, cur_arg);
      if (!sdcmd_oen_o) begin
        cap = {cap[134:0], sdcmd_o};
        cap_n++;
        if (first_lo < 0) first_lo = cyc;
      end
    end
  end

  task automatic truncate(input int r);
    if (busy_hi > r - 1) busy_hi = r - 1;
    if (rdy_hi > r - 1) rdy_hi = r - 1;
    tx_cut = r - 1;
    if (valid_c >= r) valid_c = -1;
    if (err_c >= r) err_c = -1;
    if (to_c >= r) to_c = -1;
    upd_c = r;
    upd_index = 6'd0;
    upd_arg = 32'd0;
  endtask

  // d: the request is driven while cyc == E+d, so it is sampled on edge E+d+1
  task automatic run_txn(input logic [47:0] cmd, input int d, input logic [1:0] rtype,
                         input logic [5:0] ridx, input logic [31:0] rarg,
                         input logic [119:0] rdata, input int rst_at, output int e_out);
    int c0, e, a, s;
    logic good;
    @(posedge clk_i); #1;
    c0 = cyc;
    e = c0 + 48;
    e_out = e;
    good = cmd[46] && (cmd[7:1] == crc7({88'd0, cmd[47:8]}, 40)) && cmd[0];
    cap_n = 0; first_lo = -1;
    busy_lo = c0 + 1; rdy_lo = 1; rdy_hi = 0;
    valid_c = -1; err_c = -1; to_c = -1;
    tx_s = -1; tx_len = 0; tx_cut = 1 << 30;
    upd_c = e; upd_index = cmd[45:40]; upd_arg = cmd[39:8];
    if (!good) begin
      err_c = e;
      busy_hi = e - 1;
    end else begin
      valid_c = e;
      rdy_lo = e;
      if (d + 1 <= NCR_MAX) begin
        a = e + d + 1;
        rdy_hi = a - 1;
        if (rtype == 2'd0) begin
          busy_hi = a - 1;
        end else begin
          s = (e + NCR > a + 1) ? e + NCR : a + 1;
          tx_s = s;
          tx_len = (rtype == 2'd3) ? 136 : 48;
          tx_frame = rsp_frame(rtype, (rtype == 2'd1) ? ridx : 6'h3F, rarg, rdata);
          busy_hi = s + tx_len;
        end
      end else begin
        to_c = e + NCR_MAX;
        rdy_hi = e + NCR_MAX - 1;
        busy_hi = e + NCR_MAX - 1;
      end
    end
    for (int i = 0; i < 48; i++) begin
      sdcmd_i = cmd[47 - i];
      rsp_valid_i = 1'($urandom_range(0, 1));
      rsp_type_i = 2'($urandom_range(0, 3));
      rsp_index_i = 6'($urandom_range(0, 63));
      rsp_arg_i = $urandom;
      rsp_data_i = rnd120();
      @(posedge clk_i); #1;
    end
    while (cyc <= busy_hi + 3) begin
      if (rst_at >= 0 && tx_s >= 0 && cyc == tx_s + rst_at) begin
        rst_i = 1'b1;
        truncate(cyc + 1);
      end else begin
        rst_i = 1'b0;
      end
      if (good && cyc == e + d) begin
        rsp_valid_i = 1'b1;
        rsp_type_i = rtype;
        rsp_index_i = ridx;
        rsp_arg_i = rarg;
        rsp_data_i = rdata;
      end else begin
        rsp_valid_i = (!good || cyc > e + d) ? 1'($urandom_range(0, 1)) : 1'b0;
        rsp_type_i = 2'($urandom_range(0, 3));
        rsp_index_i = 6'($urandom_range(0, 63));
        rsp_arg_i = $urandom;
        rsp_data_i = rnd120();
      end
      sdcmd_i = (cyc <= busy_hi) ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk_i); #1;
    end
    rst_i = 1'b0;
    sdcmd_i = 1'b1;
    rsp_valid_i = 1'b0;
  endtask

  task automatic run_glitch();
    int c0;
    @(posedge clk_i); #1;
    c0 = cyc;
    cap_n = 0;
    busy_lo = c0 + 1; busy_hi = c0 + 1; rdy_lo = 1; rdy_hi = 0;
    valid_c = -1; err_c = -1; to_c = -1; tx_s = -1; tx_len = 0;
    sdcmd_i = 1'b0;
    @(posedge clk_i); #1;
    sdcmd_i = 1'b0;
    @(posedge clk_i); #1;
    sdcmd_i = 1'b1;
    repeat (4) @(posedge clk_i);
    #1;
    chk("glitch_no_drive", cap_n, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: cycle %0d reached, limit 90000", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int e;
    logic [47:0] cmd;
    int d;
    int r;
    int pos;
    rst_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    rst_i = 1'b0;

    chk("model_crc_cmd0", crc7({96'd0, 40'h4000000000}, 40), 7'h4A);
    chk("model_crc_cmd8", crc7({96'd0, 40'h48000001AA}, 40), 7'h43);
    chk("model_crc_r1_cmd8", crc7({96'd0, 40'h08000001AA}, 40), 7'h09);
    chk("model_cmd55", make_cmd(6'd55, 32'd0), 48'h770000000065);

    run_txn(48'h400000000095, 0, 2'd0, 6'd0, 32'd0, '0, -1, e);
    chk("cmd0_no_drive", cap_n, 0);

    run_txn(48'h48000001AA87, 0, 2'd1, 6'd8, 32'h1AA, '0, -1, e);
    chk("cmd8_frame", cap[47:0], 48'h08000001AA13);
    chk("cmd8_len", cap_n, 48);
    chk("cmd8_start", first_lo, e + 2);

    run_txn(make_cmd(6'd41, 32'h40FF8000), 10, 2'd2, 6'd5, 32'h80FF8000, '0, -1, e);
    chk("acmd41_frame", cap[47:0], 48'h3F80FF8000FF);
    chk("acmd41_start", first_lo, e + 12);

    run_txn(48'h400000000195, 0, 2'd1, 6'd1, 32'd1, '0, -1, e);
    chk("badcrc_no_drive", cap_n, 0);
    run_txn(48'h400000000094, 0, 2'd1, 6'd1, 32'd1, '0, -1, e);
    chk("badend_no_drive", cap_n, 0);

    run_txn(48'h770000000065, 100, 2'd1, 6'd1, 32'd1, '0, -1, e);
    chk("timeout_no_drive", cap_n, 0);

    run_txn(make_cmd(6'd2, 32'd0), 0, 2'd3, 6'd0, 32'd0, '0, -1, e);
    chk("r2_len", cap_n, 136);
    chk("r2_frame", cap, {2'b00, 6'h3F, 120'd0, 8'h01});

    run_txn(make_cmd(6'd9, $urandom), 0, 2'd3, 6'd0, 32'd0, rnd120(), 50, e);
    run_txn(48'h400000000095, 0, 2'd0, 6'd0, 32'd0, '0, -1, e);

    run_glitch();

    for (int n = 0; n < 40; n++) begin
      cmd = make_cmd(6'($urandom_range(0, 63)), $urandom);
      r = $urandom_range(0, 7);
      if (r == 0) begin
        pos = $urandom_range(1, 45);
        cmd[pos] = ~cmd[pos];
      end else if (r == 1) begin
        cmd[0] = 1'b0;
      end
      d = ($urandom_range(0, 3) == 0) ? $urandom_range(55, 70) : $urandom_range(0, 12);
      run_txn(cmd, d, 2'($urandom_range(0, 3)), 6'($urandom_range(0, 63)), $urandom,
              rnd120(), -1, e);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
